block_array_loader: RTL and testbench
=====================================

Name: block_array_loader

Overview:
- Parametrised successor to the single-block memory-to-array loader in the DCT front end.
- Streams N blocks of BLK_DIM x BLK_DIM coefficients out of a 1-cycle-latency pixel memory and presents each block as a 2-D array to the DCT stage under valid/ready.
- One fill buffer plus one output register. The next block is fetched while the DCT consumes the current one.

Parameters:
- DATA_W, 32, sample width in bits.
- BLK_DIM, 8, block edge. Block holds BLK_DIM*BLK_DIM samples (PIX = 64 at default).
- MAX_BLOCKS, 32, maximum blocks per job. num_blocks width = $clog2(MAX_BLOCKS+1).
- MEM_AW, 11, pixel memory address width.

Ports:
- clock, in, 1: sole clock, rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: job start pulse. Ignored while busy=1.
- base_addr, in, MEM_AW: first sample address, sampled on accepted start.
- num_blocks, in, $clog2(MAX_BLOCKS+1): blocks in job, sampled on accepted start.
- mem_rd_en, out, 1: memory read strobe.
- mem_addr, out, MEM_AW: read address.
- mem_rd_data, in, DATA_W: read data, valid exactly 1 cycle after mem_rd_en.
- out_valid, out, 1: out_block holds a complete block.
- out_ready, in, 1: DCT accepts block.
- out_block, out, [BLK_DIM][BLK_DIM] x DATA_W: row-major block; [r][c] = sample r*BLK_DIM+c.
- out_blk_idx, out, $clog2(MAX_BLOCKS): index of the presented block within the job.
- busy, out, 1: job in progress.
- done, out, 1: one-cycle pulse when the last block is accepted.

Behaviour:
- Reset (reset_n=0 at a clock edge) clears all state. All outputs go to 0, out_block included. FSM goes to IDLE. An aborted job is dropped with no done pulse.
- FSM states:
  - IDLE: on start, latch inputs, set busy. If num_blocks==0, pulse done next cycle and stay IDLE. Otherwise go to FETCH.
  - FETCH: assert mem_rd_en every cycle. mem_addr = base + blk*PIX + k, k = 0..PIX-1, wrapping modulo 2^MEM_AW.
    - Returned data is written to fill[k_d], where k_d is k delayed by one cycle.
    - After issuing k=PIX-1, go to DRAIN.
  - DRAIN (1 cycle): capture the last sample. Then:
    - If the output register is free (out_valid=0, or out_valid&out_ready this cycle), transfer fill to out_block, set out_valid and out_blk_idx.
    - Then FETCH the next block if one remains, else go to LAST.
    - If the output register is not free, go to HOLD.
  - HOLD: no reads. Transfer as soon as the output register is free, then continue as from DRAIN.
  - LAST: wait for the final out_valid&out_ready. Then pulse done, clear busy, go to IDLE.
- Latency: start accepted at edge t. Reads issue in cycles t+1..t+PIX. First out_valid is high from cycle t+PIX+2.
- Throughput: one block per PIX+1 cycles when out_ready stays high.
- out_block and out_blk_idx are stable while out_valid=1 and out_ready=0.
- out_valid drops the cycle after acceptance unless a new block transfers in that same cycle.
- start during busy is ignored; latched parameters are unchanged.
- mem_rd_data is sampled only in the cycle after mem_rd_en.

Optional Feature:
- Macro: BLOCK_ARRAY_LOADER_LEVEL_SHIFT_EN.
- When defined: each sample is stored as mem_rd_data minus 2^(PIX_BITS-1), two's complement. PIX_BITS is the package constant, default 10, so 512 is subtracted. Provides DCT-ready signed input.
- When undefined: samples are stored unmodified.
- Latency is identical in both cases.

Decomposition:
- Package prores_dct_pkg holds:
  - BLK_DIM default.
  - PIX_BITS.
  - FSM state enum: IDLE, FETCH, DRAIN, HOLD, LAST.
  - Function computing block base offset, blk*PIX.
- One sub-module: block_addr_gen. It owns the k/blk counters and mem_addr generation with wrap, and exposes last_sample and last_block flags.

Test Plan:
- Single block: base=0, num_blocks=1, mem[i]=i, out_ready=1.
  - 64 reads at addresses 0..63.
  - out_valid in cycle t+66 with out_block[r][c]=8r+c.
  - done one cycle after acceptance.
- Backpressure: num_blocks=3, out_ready=0 for 200 cycles.
  - Block 0 held stable; block 1 fetched, then HOLD with mem_rd_en=0.
  - On release, blocks 0,1,2 delivered in order with out_blk_idx 0,1,2.
- Address wrap: base=2040, num_blocks=1.
  - Addresses 2040..2047 then 0..55, data correct.
- Edge cases:
  - num_blocks=0: done pulse one cycle after start, zero reads.
  - start asserted during busy: ignored, base_addr change has no effect.
- Reset mid-FETCH at k=30: next cycle all outputs 0 and IDLE, no done. A new start works normally.
- Macro defined, mem value 700: out_block sample = 188. Mem value 0: sample = -512 (0xFFFFFE00).

Source files
------------

// File: rtl/block_array_loader_pkg.sv
// Shared constants, FSM state type and block offset helper for the DCT
// front-end block loader.
package prores_dct_pkg;

  localparam int BLK_DIM_DEFAULT = 8;

  // Sample bit depth; the optional level shift removes 2^(PIX_BITS-1).
  localparam int PIX_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    LAST  = 3'd4
  } state_t;

  // Sample offset of block blk inside the job.
  function automatic int unsigned blk_offset(input int unsigned blk,
                                             input int unsigned pix);
    return blk * pix;
  endfunction

endpackage

// File: rtl/block_array_loader_if.sv
// Memory read port and block output stream of the loader.
//
// Output handshake: a block is transferred on every rising edge where
// out_valid and out_ready are both 1. While out_valid=1 and out_ready=0 the
// loader holds out_block and out_blk_idx stable. out_valid does not wait on
// out_ready. The memory port has no handshake: mem_rd_data is valid exactly
// one cycle after mem_rd_en.
interface block_array_loader_if #(
  parameter int DATA_W     = 32,
  parameter int BLK_DIM    = 8,
  parameter int MAX_BLOCKS = 32,
  parameter int MEM_AW     = 11
);
  localparam int IDX_W = $clog2(MAX_BLOCKS);

  logic                                        mem_rd_en;
  logic [MEM_AW-1:0]                           mem_addr;
  logic [DATA_W-1:0]                           mem_rd_data;
  logic                                        out_valid;
  logic                                        out_ready;
  logic [BLK_DIM-1:0][BLK_DIM-1:0][DATA_W-1:0] out_block;
  logic [IDX_W-1:0]                            out_blk_idx;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_block, out_blk_idx,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_block, out_blk_idx,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/block_array_loader_addr_gen.sv
// block_addr_gen: sample/block counters and wrapped pixel memory address.
// MAX_BLOCKS must be at least 2.
module block_addr_gen
  import prores_dct_pkg::*;
#(
  parameter int BLK_DIM    = 8,
  parameter int MAX_BLOCKS = 32,
  parameter int MEM_AW     = 11,
  localparam int PIX       = BLK_DIM * BLK_DIM,
  localparam int KW        = $clog2(PIX),
  localparam int NB_W      = $clog2(MAX_BLOCKS + 1),
  localparam int IDX_W     = $clog2(MAX_BLOCKS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [MEM_AW-1:0] base_in,
  input  logic [NB_W-1:0]   nblk_in,
  input  logic              step,
  input  logic              next_blk,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [KW-1:0]     k,
  output logic [IDX_W-1:0]  blk,
  output logic              last_sample,
  output logic              last_block
);

  logic [MEM_AW-1:0] base_q;
  logic [NB_W-1:0]   nblk_q;
  logic [MEM_AW-1:0] off;

  // Job parameters are latched on load; k walks the block, blk the job.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      base_q <= '0;
      nblk_q <= '0;
      k      <= '0;
      blk    <= '0;
    end else if (load) begin
      base_q <= base_in;
      nblk_q <= nblk_in;
      k      <= '0;
      blk    <= '0;
    end else if (next_blk) begin
      blk <= blk + 1'b1;
      k   <= '0;
    end else if (step) begin
      k <= k + 1'b1;
    end
  end

  // Address arithmetic is truncated to MEM_AW bits, so it wraps naturally.
  always_comb begin
    off      = MEM_AW'(blk_offset(32'(blk), 32'(PIX)));
    mem_addr = base_q + off + MEM_AW'(k);
  end

  assign last_sample = (k == KW'(PIX - 1));
  assign last_block  = ((NB_W'(blk) + 1'b1) == nblk_q);

endmodule

// File: rtl/block_array_loader.sv
// block_array_loader: streams num_blocks BLK_DIM x BLK_DIM blocks from a
// 1-cycle-latency pixel memory into a fill buffer, then hands each complete
// block to the DCT through a single output register. The next block is
// fetched while the current one waits for out_ready.
// Optional: define BLOCK_ARRAY_LOADER_LEVEL_SHIFT_EN to store every sample
// minus 2^(PIX_BITS-1) (signed DCT input); latency is unchanged.
module block_array_loader
  import prores_dct_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BLK_DIM    = BLK_DIM_DEFAULT,
  parameter int MAX_BLOCKS = 32,
  parameter int MEM_AW     = 11,
  localparam int PIX       = BLK_DIM * BLK_DIM,
  localparam int KW        = $clog2(PIX),
  localparam int NB_W      = $clog2(MAX_BLOCKS + 1),
  localparam int IDX_W     = $clog2(MAX_BLOCKS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [MEM_AW-1:0]    base_addr,
  input  logic [NB_W-1:0]      num_blocks,
  output logic                 busy,
  output logic                 done,
  output state_t               state_dbg,
  block_array_loader_if.master ifc
);

  state_t                       state;
  logic [KW-1:0]                k;
  logic [KW-1:0]                k_d;
  logic                         rd_en_d;
  logic [IDX_W-1:0]             blk;
  logic                         last_sample;
  logic                         last_block;
  logic [PIX-1:0][DATA_W-1:0]   fill;
  logic [PIX-1:0][DATA_W-1:0]   fill_next;
  logic [DATA_W-1:0]            sample;
  logic                         accept;
  logic                         out_free;
  logic                         xfer_state;
  logic                         load;
  logic                         step;
  logic                         next_blk;

  assign state_dbg  = state;
  assign accept     = ifc.out_valid && ifc.out_ready;
  assign out_free   = !ifc.out_valid || ifc.out_ready;
  assign xfer_state = (state == DRAIN) || (state == HOLD);
  assign load       = (state == IDLE) && start && (num_blocks != '0);
  assign step       = (state == FETCH) && !last_sample;
  assign next_blk   = xfer_state && out_free && !last_block;

  block_addr_gen #(
    .BLK_DIM    (BLK_DIM),
    .MAX_BLOCKS (MAX_BLOCKS),
    .MEM_AW     (MEM_AW)
  ) u_addr_gen (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (load),
    .base_in     (base_addr),
    .nblk_in     (num_blocks),
    .step        (step),
    .next_blk    (next_blk),
    .mem_addr    (ifc.mem_addr),
    .k           (k),
    .blk         (blk),
    .last_sample (last_sample),
    .last_block  (last_block)
  );

`ifdef BLOCK_ARRAY_LOADER_LEVEL_SHIFT_EN
  localparam logic [DATA_W-1:0] LEVEL_OFS = DATA_W'(1 << (PIX_BITS - 1));
  assign sample = ifc.mem_rd_data - LEVEL_OFS;
`else
  assign sample = ifc.mem_rd_data;
`endif

  // Fill buffer view including the sample returning this cycle, so the
  // DRAIN transfer already carries the last sample of the block.
  always_comb begin
    fill_next = fill;
    if (rd_en_d) fill_next[k_d] = sample;
  end

  // Control FSM, read strobe, fill buffer and output register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_en_d         <= 1'b0;
      k_d             <= '0;
      fill            <= '0;
      ifc.mem_rd_en   <= 1'b0;
      ifc.out_valid   <= 1'b0;
      ifc.out_block   <= '0;
      ifc.out_blk_idx <= '0;
    end else begin
      done    <= 1'b0;
      rd_en_d <= ifc.mem_rd_en;
      k_d     <= k;
      fill    <= fill_next;
      if (accept) ifc.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_blocks == '0) begin
              done <= 1'b1;
            end else begin
              busy          <= 1'b1;
              ifc.mem_rd_en <= 1'b1;
              state         <= FETCH;
            end
          end
        end
        FETCH: begin
          if (last_sample) begin
            ifc.mem_rd_en <= 1'b0;
            state         <= DRAIN;
          end
        end
        DRAIN, HOLD: begin
          if (out_free) begin
            ifc.out_block   <= fill_next;
            ifc.out_valid   <= 1'b1;
            ifc.out_blk_idx <= blk;
            if (last_block) begin
              state <= LAST;
            end else begin
              ifc.mem_rd_en <= 1'b1;
              state         <= FETCH;
            end
          end else begin
            state <= HOLD;
          end
        end
        LAST: begin
          if (accept) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_array_loader.sv
// Directed testbench for block_array_loader: single block, backpressure,
// address wrap, empty job, start while busy, reset mid-fetch and the
// level-shift sample values (expectations follow BLOCK_ARRAY_LOADER_LEVEL_SHIFT_EN).
module tb_block_array_loader;
  import prores_dct_pkg::*;

  localparam int DATA_W     = 32;
  localparam int BLK_DIM    = 8;
  localparam int MAX_BLOCKS = 32;
  localparam int MEM_AW     = 11;
  localparam int PIX        = 64;

  logic              clock      = 1'b0;
  logic              reset_n    = 1'b0;
  logic              start      = 1'b0;
  logic [MEM_AW-1:0] base_addr  = '0;
  logic [5:0]        num_blocks = '0;
  logic              busy;
  logic              done;
  state_t            state_dbg;
  logic [31:0]       rd_data    = '0;
  logic              ready      = 1'b0;

  logic [31:0]       mem [2048];
  logic [MEM_AW-1:0] rd_q[$];
  logic [31:0]       exp_q[$];
  int                n_cmp = 0;
  int                n_err = 0;

  block_array_loader_if #(
    .DATA_W(DATA_W), .BLK_DIM(BLK_DIM), .MAX_BLOCKS(MAX_BLOCKS), .MEM_AW(MEM_AW)
  ) bus ();

  assign bus.mem_rd_data = rd_data;
  assign bus.out_ready   = ready;

  block_array_loader #(
    .DATA_W(DATA_W), .BLK_DIM(BLK_DIM), .MAX_BLOCKS(MAX_BLOCKS), .MEM_AW(MEM_AW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_blocks (num_blocks),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg),
    .ifc        (bus)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pixel memory with one cycle read latency; every issued address is logged.
  always @(posedge clock) begin
    if (bus.mem_rd_en) begin
      rd_data <= mem[bus.mem_addr];
      rd_q.push_back(bus.mem_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] shaped(input logic [31:0] v);
`ifdef BLOCK_ARRAY_LOADER_LEVEL_SHIFT_EN
    return v - 32'd512;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one edge; returns in the first cycle after acceptance.
  task automatic do_start(input logic [MEM_AW-1:0] b, input logic [5:0] nb);
    rd_q.delete();
    base_addr  = b;
    num_blocks = nb;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n = cycle index (1 = first cycle after accepted start) of out_valid.
  task automatic wait_valid(input string tag, output int n);
    n = 1;
    while (!bus.out_valid && n < 300) begin
      tick();
      n++;
    end
    if (!bus.out_valid) check({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic check_reads(input string tag, input int b, input int cnt);
    for (int j = 0; j < cnt; j++) exp_q.push_back(32'((b + j) % 2048));
    check({tag, "_read_count"}, rd_q.size(), cnt);
    while (exp_q.size() > 0) begin
      if (rd_q.size() == 0) begin
        check({tag, "_read_missing"}, 0, 1);
        exp_q.delete();
      end else begin
        check({tag, "_read_addr"}, 32'(rd_q.pop_front()), exp_q.pop_front());
      end
    end
    rd_q.delete();
  endtask

  task automatic check_block(input string tag, input int b);
    for (int i = 0; i < PIX; i++)
      check({tag, "_sample"}, bus.out_block[i / BLK_DIM][i % BLK_DIM],
            shaped(mem[(b + i) % 2048]));
  endtask

  // Called in the acceptance cycle of the final block.
  task automatic finish_job(input string tag);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_clear"}, busy, 0);
    check({tag, "_state_idle"}, state_dbg, IDLE);
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int n;
    int acc;
    int cyc;
    logic seen_done;

    for (int i = 0; i < 2048; i++) mem[i] = 32'h0003_0000 | 32'(i);

    // Reset state.
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_block_zero", bus.out_block == '0, 1);
    check("rst_state", state_dbg, IDLE);
    reset_n = 1'b1;
    tick();

    // Single block from address 0, mem[i] = i.
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i);
    ready = 1'b1;
    do_start(11'd0, 6'd1);
    check("t1_busy", busy, 1);
    check("t1_rd_en_first", bus.mem_rd_en, 1);
    wait_valid("t1", n);
    check("t1_latency", n, 66);
    check("t1_idx", bus.out_blk_idx, 0);
    check("t1_r3c5", bus.out_block[3][5], shaped(32'd29));
    check_reads("t1", 0, 64);
    check_block("t1", 0);
    finish_job("t1");

    // Backpressure: three blocks, DCT stalled for 200 cycles.
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0003_0000 | 32'(i);
    ready = 1'b0;
    do_start(11'd100, 6'd3);
    repeat (199) tick();
    check("bp_state_hold", state_dbg, HOLD);
    check("bp_rd_en_off", bus.mem_rd_en, 0);
    check("bp_valid", bus.out_valid, 1);
    check("bp_idx_held", bus.out_blk_idx, 0);
    check_block("bp_blk0_held", 100);
    check_reads("bp_two_blocks", 100, 128);
    ready = 1'b1;
    acc = 0;
    cyc = 0;
    while (!done && cyc < 400) begin
      if (bus.out_valid) begin
        check("bp_idx_order", bus.out_blk_idx, acc);
        check("bp_first_sample", bus.out_block[0][0], shaped(mem[100 + 64 * acc]));
        check("bp_last_sample", bus.out_block[7][7], shaped(mem[163 + 64 * acc]));
        acc++;
      end
      tick();
      cyc++;
    end
    check("bp_blocks_delivered", acc, 3);
    check("bp_done", done, 1);
    check_reads("bp_third_block", 228, 64);
    tick();

    // Address wrap from 2040.
    do_start(11'd2040, 6'd1);
    wait_valid("wrap", n);
    check("wrap_latency", n, 66);
    check_reads("wrap", 2040, 64);
    check_block("wrap", 2040);
    finish_job("wrap");

    // Empty job.
    do_start(11'd0, 6'd0);
    check("zero_done", done, 1);
    check("zero_rd_en", bus.mem_rd_en, 0);
    tick();
    check("zero_done_one_cycle", done, 0);
    repeat (3) tick();
    check("zero_reads", rd_q.size(), 0);

    // Start while busy is ignored.
    do_start(11'd200, 6'd1);
    repeat (9) tick();
    base_addr  = 11'd600;
    num_blocks = 6'd5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("busy_start", n);
    check("busy_start_idx", bus.out_blk_idx, 0);
    check_block("busy_start", 200);
    finish_job("busy_start");
    check_reads("busy_start", 200, 64);

    // Reset while fetching sample k=30.
    do_start(11'd0, 6'd2);
    repeat (30) tick();
    check("rstmid_addr_k30", bus.mem_addr, 30);
    reset_n = 1'b0;
    tick();
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_rd_en", bus.mem_rd_en, 0);
    check("rstmid_addr", bus.mem_addr, 0);
    check("rstmid_valid", bus.out_valid, 0);
    check("rstmid_idx", bus.out_blk_idx, 0);
    check("rstmid_block_zero", bus.out_block == '0, 1);
    check("rstmid_state", state_dbg, IDLE);
    reset_n   = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("rstmid_no_done", seen_done, 0);
    do_start(11'd64, 6'd1);
    wait_valid("rstmid_restart", n);
    check("rstmid_restart_latency", n, 66);
    check_block("rstmid_restart", 64);
    finish_job("rstmid_restart");

    // Level-shift sample values.
    mem[300] = 32'd700;
    mem[301] = 32'd0;
    do_start(11'd300, 6'd1);
    wait_valid("shift", n);
`ifdef BLOCK_ARRAY_LOADER_LEVEL_SHIFT_EN
    check("shift_700", bus.out_block[0][0], 32'd188);
    check("shift_0", bus.out_block[0][1], 32'hFFFF_FE00);
`else
    check("shift_700", bus.out_block[0][0], 32'd700);
    check("shift_0", bus.out_block[0][1], 32'd0);
`endif
    finish_job("shift");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
